aes_job_arbiter: RTL
====================

Name: aes_job_arbiter

Overview:
- Shares one AES encrypt engine and one AES decrypt engine between two independent job requesters, for example the I2C front end and a local host port.
- Arbitrates round-robin, captures the winner's operand/key/op, and launches the matching engine with a level start.
- Waits for engine done or a watchdog timeout, then returns the result to the granted requester with a one-cycle done pulse.
- Sits between the requester-side controllers and the cipher engines.

Parameters:
- TIMEOUT, 1023, max cycles in WAIT before the job is aborted with error (1..65535).
- CW, 16, watchdog counter width; must hold TIMEOUT.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req0  input  1  requester 0 job request, level.
- op0  input  1  requester 0 operation: 0 encrypt, 1 decrypt.
- data0  input  128  requester 0 plaintext/ciphertext.
- key0  input  128  requester 0 key.
- req1, op1, data1, key1  input  1/1/128/128  same for requester 1.
- done0  output  1  one-cycle pulse: requester 0 job finished.
- done1  output  1  one-cycle pulse: requester 1 job finished.
- err  output  1  valid with done0/done1: 1 = timeout abort.
- result  output  128  job result, valid with done0/done1, held until the next delivery.
- busy  output  1  high in any state other than IDLE.
- eng_data  output  128  captured operand to the engines.
- eng_key  output  128  captured key to the engines.
- enc_start  output  1  encrypt engine start, level.
- dec_start  output  1  decrypt engine start, level.
- enc_done  input  1  encrypt engine done.
- dec_done  input  1  decrypt engine done.
- enc_out  input  128  encrypt engine result.
- dec_out  input  128  decrypt engine result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: done0, done1, err, result, busy, eng_data, eng_key, enc_start, dec_start.
  - last_grant=1, so requester 0 wins the first tie.
  - Watchdog counter 0.
- Reset mid-job drops enc_start/dec_start immediately. No done pulse is issued and the job is lost.
- States: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE:
  - Samples req0/req1 each cycle.
  - Only one request: grant it.
  - Both requesting: grant the requester that is not last_grant.
  - On grant: capture data/key/op of the winner into eng_data/eng_key/op_r, record gnt, update last_grant, go to LAUNCH.
  - No request: stay.
- LAUNCH (1 cycle):
  - Assert enc_start if op_r=0, else dec_start.
  - Clear the watchdog and go to WAIT.
  - Exactly one start is ever high.
- WAIT:
  - Start stays high. Watchdog increments each cycle.
  - Only the done of the selected engine counts; the other engine's done is ignored.
  - Selected done=1: latch result from enc_out/dec_out, err=0, drop start, go to DELIVER.
  - Watchdog reaches TIMEOUT first: result=0, err=1, drop start, go to DELIVER.
  - Done and timeout in the same cycle: done wins, err=0.
- DELIVER (1 cycle):
  - done0 pulses if gnt=0, done1 pulses if gnt=1; err is valid in the same cycle.
  - Go to IDLE.
- Latency: grant at cycle g. Start is high from g+1. Engine done seen at cycle d gives the done pulse at d+1. Minimum request-to-done is 4 cycles with a 1-cycle engine.
- Requester handshake:
  - Requesters hold req until they see their done, and drop req in the same cycle as the done pulse.
  - A req still high in the first IDLE cycle after DELIVER counts as a new job.
  - Inputs may change freely after grant; the captured copies are used.
  - A req arriving while busy waits. Nothing is queued beyond the level req.
- result/err hold their values between deliveries. err clears at the next DELIVER with success.
- busy = (state != IDLE), registered.
- Fairness: with both requesters continuously requesting, grants strictly alternate.

Test Plan:
- Reset, then req0=1, op0=0, data0=00112233445566778899aabbccddeeff, key0=000102030405060708090a0b0c0d0e0f, using a model engine → enc_start rises 2 cycles after req0; done0 pulses once; result=69c4e0d86a7b0430d8cdb78070b4c55a; err=0; dec_start never high.
- req1, op1=1, data1=69c4…c55a, same key → dec_start only; done1 with result=00112233…eeff.
- req0 and req1 raised in the same cycle, both held, then re-raised after each done → grant order 0,1,0,1; no done0/done1 overlap.
- TIMEOUT=8, engine never asserts done → start drops after 8 WAIT cycles; done pulse with err=1 and result=0; the next good job delivers err=0.
- enc_done and timeout reached in the same cycle → err=0 and the result is the engine output.
- reset=0 asserted in the middle of WAIT → start, busy and done all 0 immediately; after release, a new job completes normally with requester 0 winning the first tie.

Source files
------------

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one AES encrypt engine and one AES decrypt engine
// between two job requesters. Requesters are served round-robin. The winner's
// operand, key and operation are captured, and the matching engine is started.
// The arbiter then waits for that engine's done or a watchdog timeout, and
// returns the result with a one-cycle done pulse to the granted requester.
module aes_job_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int CW      = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic         op0,
  input  logic [127:0] data0,
  input  logic [127:0] key0,
  input  logic         req1,
  input  logic         op1,
  input  logic [127:0] data1,
  input  logic [127:0] key1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic [127:0] result,
  output logic         busy,
  output logic [127:0] eng_data,
  output logic [127:0] eng_key,
  output logic         enc_start,
  output logic         dec_start,
  input  logic         enc_done,
  input  logic         dec_done,
  input  logic [127:0] enc_out,
  input  logic [127:0] dec_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } stateT;

  stateT          r_state;
  stateT          w_nextState;

  logic           r_lastGrant;
  logic           r_gnt;
  logic           r_opR;
  logic [CW-1:0]  r_wdog;
  logic [127:0]   r_engData;
  logic [127:0]   r_engKey;
  logic [127:0]   r_result;
  logic           r_err;
  logic           r_done0;
  logic           r_done1;
  logic           r_encStart;
  logic           r_decStart;
  logic           r_busy;

  logic           w_anyReq;
  logic           w_grantSel;
  logic           w_selDone;
  logic           w_timeout;

  // With both requesting, the requester that did not win last time goes next.
  assign w_anyReq   = req0 | req1;
  assign w_grantSel = (req0 && req1) ? ~r_lastGrant : req1;
  assign w_selDone  = r_opR ? dec_done : enc_done;
  assign w_timeout  = (r_wdog == CW'(TIMEOUT - 1));

  assign done0     = r_done0;
  assign done1     = r_done1;
  assign err       = r_err;
  assign result    = r_result;
  assign busy      = r_busy;
  assign eng_data  = r_engData;
  assign eng_key   = r_engKey;
  assign enc_start = r_encStart;
  assign dec_start = r_decStart;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: the engine's done takes priority over the watchdog.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (w_anyReq) w_nextState = ST_LAUNCH;
      ST_LAUNCH:  w_nextState = ST_WAIT;
      ST_WAIT:    if (w_selDone || w_timeout) w_nextState = ST_DELIVER;
      ST_DELIVER: w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // Job datapath: capture on grant, start engine, collect result, pulse done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lastGrant <= 1'b1;
      r_gnt       <= 1'b0;
      r_opR       <= 1'b0;
      r_wdog      <= '0;
      r_engData   <= '0;
      r_engKey    <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_encStart  <= 1'b0;
      r_decStart  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_nextState != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_gnt       <= w_grantSel;
            r_lastGrant <= w_grantSel;
            r_opR       <= w_grantSel ? op1   : op0;
            r_engData   <= w_grantSel ? data1 : data0;
            r_engKey    <= w_grantSel ? key1  : key0;
          end
        end
        ST_LAUNCH: begin
          r_wdog     <= '0;
          r_encStart <= ~r_opR;
          r_decStart <= r_opR;
        end
        ST_WAIT: begin
          if (w_selDone) begin
            r_result   <= r_opR ? dec_out : enc_out;
            r_err      <= 1'b0;
            r_encStart <= 1'b0;
            r_decStart <= 1'b0;
            r_done0    <= ~r_gnt;
            r_done1    <= r_gnt;
          end else if (w_timeout) begin
            r_result   <= '0;
            r_err      <= 1'b1;
            r_encStart <= 1'b0;
            r_decStart <= 1'b0;
            r_done0    <= ~r_gnt;
            r_done1    <= r_gnt;
          end else begin
            r_wdog <= r_wdog + CW'(1);
          end
        end
        ST_DELIVER: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
        end
        default: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
        end
      endcase
    end
  end

endmodule
